calc_sequencer: RTL and testbench



---
 rtl/calc_pkg.sv | 45 ++++
 rtl/calc_sequencer_debounce.sv | 46 ++++
 rtl/calc_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and seven-segment glyphs for the
// two-operand single-digit calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A,
    S_OP,
    S_B,
    S_RES
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_t;

  localparam int DIGITS = 6;

  localparam logic [7:0] G_A     = 8'b10001000;
  localparam logic [7:0] G_S     = 8'b10010010;
  localparam logic [7:0] G_P     = 8'b10001100;
  localparam logic [7:0] G_EQ    = 8'b10110111;
  localparam logic [7:0] G_MINUS = 8'b10111111;
  localparam logic [7:0] G_BLANK = 8'hFF;

  function automatic logic [7:0] font(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/calc_sequencer_debounce.sv
// Active-low key debouncer: two-flop synchronizer, stability
// counter, single-cycle pulse on an accepted press.
module key_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // synchronize, then accept a new level once it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: key handling, entry/compute FSM and
// six-digit multiplexed seven-segment scan.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1,
  input  logic       key2,
  input  logic       key3,
  output logic [3:0] LED,
  output logic [7:0] sseg,
  output logic [5:0] en
);

  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  logic press1, press2, press3;
  logic do1, do2, do3;

  state_t     state, state_nx;
  op_t        op, op_nx;
  logic [3:0] a, a_nx;
  logic [3:0] b, b_nx;
  logic       neg, neg_nx;
  logic [6:0] mag, mag_nx;

  logic       res_neg;
  logic [6:0] res_mag;
  logic [6:0] ax, bx;
  logic [3:0] tens, ones;

  logic [SCW-1:0] scan_cnt;
  logic [2:0]     pos;
  logic [7:0]     glyph;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_k1 (
    .clk   (clk),
    .rst   (rst),
    .key_n (key1),
    .press (press1)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_k2 (
    .clk   (clk),
    .rst   (rst),
    .key_n (key2),
    .press (press2)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_k3 (
    .clk   (clk),
    .rst   (rst),
    .key_n (key3),
    .press (press3)
  );

  assign do3 = press3;
  assign do2 = press2 & ~press3;
  assign do1 = press1 & ~press2 & ~press3;

  assign ax   = {3'b000, a};
  assign bx   = {3'b000, b};
  assign tens = 4'(mag / 7'd10);
  assign ones = 4'(mag % 7'd10);

  // result of the current operands, latched on compute
  always_comb begin
    res_neg = 1'b0;
    res_mag = '0;
    case (op)
      OP_ADD: res_mag = ax + bx;
      OP_SUB: begin
        if (a < b) begin
          res_neg = 1'b1;
          res_mag = bx - ax;
        end else begin
          res_mag = ax - bx;
        end
      end
      default: res_mag = ax * bx;
    endcase
  end

  // next-state and operand updates from the winning key
  always_comb begin
    state_nx = state;
    op_nx    = op;
    a_nx     = a;
    b_nx     = b;
    neg_nx   = neg;
    mag_nx   = mag;
    unique case (1'b1)
      do3: begin
        if (state == S_RES) begin
          state_nx = S_A;
          op_nx    = OP_ADD;
          a_nx     = '0;
          b_nx     = '0;
          neg_nx   = 1'b0;
          mag_nx   = '0;
        end else begin
          state_nx = S_RES;
          neg_nx   = res_neg;
          mag_nx   = res_mag;
        end
      end
      do2: begin
        case (state)
          S_A:     state_nx = S_OP;
          S_OP:    state_nx = S_B;
          default: state_nx = S_A;
        endcase
      end
      do1: begin
        case (state)
          S_A: a_nx = (a == 4'd9) ? 4'd0 : a + 4'd1;
          S_B: b_nx = (b == 4'd9) ? 4'd0 : b + 4'd1;
          S_OP: begin
            case (op)
              OP_ADD:  op_nx = OP_SUB;
              OP_SUB:  op_nx = OP_MUL;
              default: op_nx = OP_ADD;
            endcase
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // FSM and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
      op    <= OP_ADD;
      a     <= '0;
      b     <= '0;
      neg   <= 1'b0;
      mag   <= '0;
    end else begin
      state <= state_nx;
      op    <= op_nx;
      a     <= a_nx;
      b     <= b_nx;
      neg   <= neg_nx;
      mag   <= mag_nx;
    end
  end

  // one-hot state indicator
  always_comb begin
    case (state)
      S_A:     LED = 4'b0001;
      S_OP:    LED = 4'b0010;
      S_B:     LED = 4'b0100;
      default: LED = 4'b1000;
    endcase
  end

  // glyph for the slot about to be shown, dp lit on the edited field
  always_comb begin
    glyph = G_BLANK;
    case (pos)
      3'd0: glyph = font(a);
      3'd1: begin
        case (op)
          OP_ADD:  glyph = G_A;
          OP_SUB:  glyph = G_S;
          default: glyph = G_P;
        endcase
      end
      3'd2: glyph = font(b);
      3'd3: if (state == S_RES) glyph = G_EQ;
      3'd4: begin
        if (state == S_RES) begin
          if (tens != 4'd0) glyph = font(tens);
          else if (neg)     glyph = G_MINUS;
        end
      end
      3'd5: if (state == S_RES) glyph = font(ones);
      default: ;
    endcase
    if ((pos == 3'd0 && state == S_A) ||
        (pos == 3'd1 && state == S_OP) ||
        (pos == 3'd2 && state == S_B))
      glyph[7] = 1'b0;
  end

  // digit scan: on each strobe drive one slot and step to the next
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      pos      <= '0;
      en       <= 6'b111111;
      sseg     <= G_BLANK;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      pos      <= (pos == 3'(DIGITS - 1)) ? 3'd0 : pos + 3'd1;
      en       <= ~(6'b000001 << pos);
      sseg     <= glyph;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural model checked every
// cycle, directed literal checks and random key traffic.
module tb_calc_sequencer;

  localparam int DB = 4;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key1 = 1'b1;
  logic       key2 = 1'b1;
  logic       key3 = 1'b1;
  logic [3:0] LED;
  logic [7:0] sseg;
  logic [5:0] en;

  int total = 0;
  int bad = 0;

  calc_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .SCAN_DIV(SD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .key1 (key1),
    .key2 (key2),
    .key3 (key3),
    .LED  (LED),
    .sseg (sseg),
    .en   (en)
  );

  always #5 clk = ~clk;

  logic [7:0] FONT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // model state: 0=A 1=OP 2=B 3=RES, op 0=ADD 1=SUB 2=MUL
  int m_state, m_op, m_a, m_b, m_res;
  int m_pos, m_tick;
  logic [5:0] m_en;
  logic [7:0] m_sseg;
  bit   m_press [3];
  int   dq [3][2];
  int   hq [3][DB];
  int   hn [3];
  int   lvl [3];
  bit   valid = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int key_now(input int k);
    case (k)
      0: return int'(key1);
      1: return int'(key2);
      default: return int'(key3);
    endcase
  endfunction

  function automatic logic [7:0] m_glyph(input int p);
    logic [7:0] g;
    int mag;
    mag = (m_res < 0) ? -m_res : m_res;
    g = 8'hFF;
    case (p)
      0: g = FONT[m_a];
      1: g = (m_op == 0) ? 8'h88 : (m_op == 1) ? 8'h92 : 8'h8C;
      2: g = FONT[m_b];
      3: if (m_state == 3) g = 8'hB7;
      4: if (m_state == 3) begin
        if (mag >= 10) g = FONT[mag / 10];
        else if (m_res < 0) g = 8'hBF;
      end
      5: if (m_state == 3) g = FONT[mag % 10];
      default: ;
    endcase
    if (p < 3 && p == m_state) g[7] = 1'b0;
    return g;
  endfunction

  // behavioural model, advanced on every rising edge
  always @(posedge clk) begin
    bit np [3];
    int seen;
    bit flip;
    if (rst) begin
      valid = 1;
      m_state = 0; m_op = 0; m_a = 0; m_b = 0; m_res = 0;
      m_pos = 0; m_tick = 0; m_en = 6'h3F; m_sseg = 8'hFF;
      for (int k = 0; k < 3; k++) begin
        m_press[k] = 0; dq[k][0] = 1; dq[k][1] = 1;
        hn[k] = 0; lvl[k] = 1;
      end
    end else begin
      if (m_tick == SD - 1) begin
        m_tick = 0;
        m_en = ~(6'b1 << m_pos);
        m_sseg = m_glyph(m_pos);
        m_pos = (m_pos + 1) % 6;
      end else begin
        m_tick++;
      end
      if (m_press[2]) begin
        if (m_state == 3) begin
          m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_state = 0;
        end else begin
          m_res = (m_op == 0) ? m_a + m_b :
                  (m_op == 1) ? m_a - m_b : m_a * m_b;
          m_state = 3;
        end
      end else if (m_press[1]) begin
        m_state = (m_state == 3) ? 0 : (m_state + 1) % 3;
      end else if (m_press[0]) begin
        case (m_state)
          0: m_a = (m_a + 1) % 10;
          1: m_op = (m_op + 1) % 3;
          2: m_b = (m_b + 1) % 10;
          default: ;
        endcase
      end
      for (int k = 0; k < 3; k++) begin
        seen = dq[k][0];
        dq[k][0] = dq[k][1];
        dq[k][1] = key_now(k);
        for (int i = 0; i < DB - 1; i++) hq[k][i] = hq[k][i+1];
        hq[k][DB-1] = seen;
        if (hn[k] < DB) hn[k]++;
        flip = (hn[k] == DB);
        for (int i = 0; i < DB; i++)
          if (hq[k][i] == lvl[k]) flip = 0;
        np[k] = 0;
        if (flip) begin
          lvl[k] = seen;
          np[k] = (seen == 0);
        end
      end
      for (int k = 0; k < 3; k++) m_press[k] = np[k];
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (valid) begin
      check("led", {28'd0, LED}, 32'(1 << m_state));
      check("en", {26'd0, en}, {26'd0, m_en});
      check("sseg", {24'd0, sseg}, {24'd0, m_sseg});
    end
  end

  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge clk);
    key1 = ~mask[0];
    key2 = ~mask[1];
    key3 = ~mask[2];
    repeat (hold) @(negedge clk);
    key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic tap(input logic [2:0] mask, input int n);
    for (int i = 0; i < n; i++) press(mask, 6);
  endtask

  task automatic slot(input int p, input string nm,
                      input logic [7:0] exp);
    logic [5:0] tgt;
    logic [5:0] prev;
    bit hit;
    tgt = ~(6'b1 << p);
    prev = en;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (en == tgt && prev != tgt) hit = 1;
      prev = en;
    end
    check({nm, "_en"}, {26'd0, en}, {26'd0, tgt});
    check(nm, {24'd0, sseg}, {24'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int hold, gap;
    logic [2:0] mask;
    repeat (3) @(negedge clk);
    check("rst_led", {28'd0, LED}, 32'h1);
    check("rst_en", {26'd0, en}, 32'h3F);
    check("rst_sseg", {24'd0, sseg}, 32'hFF);
    rst = 1'b0;
    slot(0, "first_strobe", 8'h40);

    tap(3'b001, 11);
    slot(0, "a_wrap", 8'h79);
    press(3'b001, 2);
    slot(0, "glitch", 8'h79);

    tap(3'b001, 6);
    tap(3'b010, 1);
    tap(3'b001, 2);
    tap(3'b010, 1);
    tap(3'b001, 9);
    tap(3'b100, 1);
    check("mul_led", {28'd0, LED}, 32'h8);
    slot(5, "mul_ones", 8'hB0);
    slot(4, "mul_tens", 8'h82);
    slot(3, "mul_eq", 8'hB7);

    tap(3'b100, 1);
    tap(3'b001, 2);
    tap(3'b010, 1);
    tap(3'b001, 1);
    tap(3'b010, 1);
    tap(3'b001, 5);
    tap(3'b100, 1);
    slot(4, "sub_minus", 8'hBF);
    slot(5, "sub_ones", 8'hB0);
    tap(3'b100, 1);
    check("clr_led", {28'd0, LED}, 32'h1);
    slot(0, "clr_a", 8'h40);
    slot(1, "clr_op", 8'h88);
    slot(2, "clr_b", 8'hC0);

    tap(3'b010, 2);
    tap(3'b001, 3);
    press(3'b110, 6);
    check("prio_led", {28'd0, LED}, 32'h8);
    slot(5, "prio_res", 8'hB0);
    slot(4, "prio_tens", 8'hFF);

    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_led", {28'd0, LED}, 32'h1);
    check("mid_en", {26'd0, en}, 32'h3F);
    check("mid_sseg", {24'd0, sseg}, 32'hFF);
    repeat (30) @(negedge clk);
    check("post_led", {28'd0, LED}, 32'h1);
    slot(0, "post_a", 8'h40);

    for (int n = 0; n < 400; n++) begin
      mask = 3'($urandom_range(1, 7));
      hold = $urandom_range(1, 9);
      gap = $urandom_range(1, 12);
      @(negedge clk);
      key1 = ~mask[0]; key2 = ~mask[1]; key3 = ~mask[2];
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        rst = ($urandom_range(0, 60) == 0);
      end
      rst = 1'b0;
      key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
      repeat (gap) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
